// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (I) and data path (D) share one
// downstream memory port. Each port has a single-entry request slot, at most
// one transaction is outstanding, ties are broken round-robin, and a hung
// transaction is aborted after TIMEOUT busy cycles (0 disables the abort).
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_valid,
  input  logic [XLEN-1:0]   imem_addr,
  output logic              imem_ready,
  output logic [XLEN-1:0]   imem_rdata,
  input  logic              dmem_valid,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN/8-1:0] dmem_wstrb,
  output logic              dmem_ready,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [1:0]        error
);

  localparam int SW    = XLEN / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;

  state_t           state, state_nxt;
  logic             owner_i;      // 1: outstanding transaction belongs to port I
  logic             last_i;       // 1: most recently completed owner was port I
  logic             pend_i, pend_d;
  logic [XLEN-1:0]  slot_i_addr;
  logic [XLEN-1:0]  slot_d_addr, slot_d_wdata;
  logic [SW-1:0]    slot_d_wstrb;
  logic [CNT_W-1:0] cnt;

  logic tmo, done;
  logic out_i, out_d;
  logic drop_i, drop_d;
  logic want_i, want_d;
  logic sel_i, sel_d;

  // Completion/abort detection, request drop detection and IDLE selection.
  // A request strobed while IDLE competes on the same edge it arrives, which
  // gives the one-cycle valid-to-mem_valid latency.
  always_comb begin
    tmo    = (TIMEOUT > 0) && (state == BUSY) && !mem_ready &&
             (cnt == CNT_W'(TIMEOUT - 1));
    done   = (state == BUSY) && (mem_ready || tmo);
    out_i  = (state == BUSY) &&  owner_i && !done;
    out_d  = (state == BUSY) && !owner_i && !done;
    drop_i = imem_valid && (pend_i || out_i);
    drop_d = dmem_valid && (pend_d || out_d);
    want_i = pend_i || imem_valid;
    want_d = pend_d || dmem_valid;
    sel_i  = (state == IDLE) && want_i && (!want_d || !last_i);
    sel_d  = (state == IDLE) && want_d && !sel_i;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_i || sel_d) state_nxt = BUSY;
      BUSY:    if (done)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion routing: only the owner sees ready; aborts return zero data
  always_comb begin
    imem_ready = done &&  owner_i;
    dmem_ready = done && !owner_i;
    imem_rdata = (imem_ready && mem_ready) ? mem_rdata : '0;
    dmem_rdata = (dmem_ready && mem_ready) ? mem_rdata : '0;
  end

  // Pending slots: load on an accepted strobe unless it is issued directly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_i       <= 1'b0;
      pend_d       <= 1'b0;
      slot_i_addr  <= '0;
      slot_d_addr  <= '0;
      slot_d_wdata <= '0;
      slot_d_wstrb <= '0;
    end else begin
      if (sel_i) begin
        pend_i <= 1'b0;
      end else if (imem_valid && !drop_i) begin
        pend_i      <= 1'b1;
        slot_i_addr <= imem_addr;
      end
      if (sel_d) begin
        pend_d <= 1'b0;
      end else if (dmem_valid && !drop_d) begin
        pend_d       <= 1'b1;
        slot_d_addr  <= dmem_addr;
        slot_d_wdata <= dmem_wdata;
        slot_d_wstrb <= dmem_wstrb;
      end
    end
  end

  // Downstream request issue, ownership, busy counter and round-robin history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      owner_i   <= 1'b0;
      last_i    <= 1'b1;
      cnt       <= '0;
    end else begin
      mem_valid <= sel_i || sel_d;
      if (sel_i) begin
        mem_instr <= 1'b1;
        mem_addr  <= pend_i ? slot_i_addr : imem_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        owner_i   <= 1'b1;
        cnt       <= '0;
      end else if (sel_d) begin
        mem_instr <= 1'b0;
        mem_addr  <= pend_d ? slot_d_addr  : dmem_addr;
        mem_wdata <= pend_d ? slot_d_wdata : dmem_wdata;
        mem_wstrb <= pend_d ? slot_d_wstrb : dmem_wstrb;
        owner_i   <= 1'b0;
        cnt       <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (done) last_i <= owner_i;
      end
    end
  end

  // Sticky error flags: [0] dropped request, [1] timeout abort
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) error <= 2'b00;
    else        error <= error | {tmo, drop_i || drop_d};
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model built
// from request queues and a simple busy/latency memory responder.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int TMO  = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  error;

  always #5 clock = ~clock;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .error      (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  req_t        q_i[$];
  req_t        q_d[$];
  bit          m_busy, m_own_i, m_last_i;
  int          m_age, m_lat;
  int          lat_fix = -1;
  logic [1:0]  m_err;
  bit          g_flag, g_instr;
  req_t        g_req;
  bit          rd_fix_en = 1'b0;
  logic [31:0] rd_fix_val = 32'h0;

  // Observation log
  logic [32:0] glog[$];
  int          gcyc[$];
  int          dready_cyc;
  logic [31:0] dready_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_i.delete();
    q_d.delete();
    m_busy   = 1'b0;
    m_own_i  = 1'b0;
    m_last_i = 1'b1;
    m_age    = 0;
    m_lat    = 0;
    m_err    = 2'b00;
    g_flag   = 1'b0;
    g_instr  = 1'b0;
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_addr  = 32'h0;
    dmem_valid = 1'b0; dmem_addr  = 32'h0;
    dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    mem_ready  = 1'b0; mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model across the following rising edge.
  task automatic cycle(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da,
                       input logic [31:0] dw, input logic [3:0] ds);
    logic        mr, tmo, done, e_ir, e_dr, take_i;
    logic [31:0] mrd, e_ird, e_drd;
    bit          out_i, out_d;
    req_t        r;
    @(negedge clock);
    cyc++;
    if (m_busy) mr = (m_age == m_lat);
    else        mr = ($urandom_range(0, 7) == 0);
    mrd = rd_fix_en ? rd_fix_val : $urandom;
    imem_valid = iv; imem_addr = ia;
    dmem_valid = dv; dmem_addr = da; dmem_wdata = dw; dmem_wstrb = ds;
    mem_ready  = mr; mem_rdata = mrd;
    #1;
    tmo   = m_busy && !mr && (m_age == TMO - 1);
    done  = m_busy && (mr || tmo);
    e_ir  = done &&  m_own_i;
    e_dr  = done && !m_own_i;
    e_ird = (e_ir && mr) ? mrd : 32'h0;
    e_drd = (e_dr && mr) ? mrd : 32'h0;
    chk("mem_valid", 64'(mem_valid), 64'(g_flag));
    if (g_flag) begin
      chk("mem_instr", 64'(mem_instr), 64'(g_instr));
      chk("mem_addr",  64'(mem_addr),  64'(g_req.addr));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(g_req.wstrb));
      if (!g_instr) chk("mem_wdata", 64'(mem_wdata), 64'(g_req.wdata));
    end
    chk("imem_ready", 64'(imem_ready), 64'(e_ir));
    chk("imem_rdata", 64'(imem_rdata), 64'(e_ird));
    chk("dmem_ready", 64'(dmem_ready), 64'(e_dr));
    chk("dmem_rdata", 64'(dmem_rdata), 64'(e_drd));
    chk("error",      64'(error),      64'(m_err));
    if (mem_valid) begin
      glog.push_back({mem_instr, mem_addr});
      gcyc.push_back(cyc);
    end
    if (dmem_ready) begin
      dready_cyc = cyc;
      dready_rd  = dmem_rdata;
    end
    // Capture: one slot per port; strobes on a full slot or on a port whose
    // transaction is still open are dropped and flagged.
    out_i = m_busy &&  m_own_i && !done;
    out_d = m_busy && !m_own_i && !done;
    if (iv) begin
      if (q_i.size() != 0 || out_i) m_err[0] = 1'b1;
      else begin
        r.addr = ia; r.wdata = 32'h0; r.wstrb = 4'h0;
        q_i.push_back(r);
      end
    end
    if (dv) begin
      if (q_d.size() != 0 || out_d) m_err[0] = 1'b1;
      else begin
        r.addr = da; r.wdata = dw; r.wstrb = ds;
        q_d.push_back(r);
      end
    end
    g_flag = 1'b0;
    if (!m_busy) begin
      if (q_i.size() != 0 && q_d.size() != 0) take_i = !m_last_i;
      else                                    take_i = (q_i.size() != 0);
      if (q_i.size() != 0 || q_d.size() != 0) begin
        g_req   = take_i ? q_i.pop_front() : q_d.pop_front();
        g_instr = take_i;
        g_flag  = 1'b1;
        m_busy  = 1'b1;
        m_own_i = take_i;
        m_age   = 0;
        m_lat   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 5));
      end
    end else if (done) begin
      m_busy   = 1'b0;
      m_last_i = m_own_i;
      if (tmo) m_err[1] = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    int  g0, c1;
    logic iv, dv;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    dready_cyc = -1;
    dready_rd  = 32'h0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_instr", 64'(mem_instr), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_error",     64'(error),     64'd0);
    chk("rst_readies",   64'({imem_ready, dmem_ready}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Single D read
    lat_fix = 2; rd_fix_en = 1'b1; rd_fix_val = 32'hDEADBEEF;
    g0 = glog.size();
    c1 = cyc + 1;
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 32'h0, 4'h0);
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("dread_ngrant", 64'(glog.size() - g0), 64'd1);
    chk("dread_grant",  64'(glog[g0]), 64'({1'b0, 32'h100}));
    chk("dread_gcyc",   64'(gcyc[g0] - c1), 64'd1);
    chk("dread_rcyc",   64'(dready_cyc - c1), 64'd3);
    chk("dread_rdata",  64'(dready_rd), 64'hDEADBEEF);
    rd_fix_en = 1'b0;

    // Tie after reset: D wins first
    do_reset();
    lat_fix = 0;
    g0 = glog.size();
    cycle(1'b1, 32'h0, 1'b1, 32'h200, 32'h0, 4'h0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("tie_first",  64'(glog[g0]),   64'({1'b0, 32'h200}));
    chk("tie_second", 64'(glog[g0+1]), 64'({1'b1, 32'h0}));
    chk("tie_gap",    64'(gcyc[g0+1] - gcyc[g0]), 64'd2);

    // Round-robin with both ports re-requesting
    do_reset();
    lat_fix = 1;
    g0 = glog.size();
    for (int k = 0; k < 80 && glog.size() < g0 + 6; k++) begin
      iv = (q_i.size() == 0) && !(m_busy &&  m_own_i);
      dv = (q_d.size() == 0) && !(m_busy && !m_own_i);
      cycle(iv, 32'h1000 + 32'(k), dv, 32'h2000 + 32'(k), $urandom, 4'h3);
    end
    chk("rr_ngrant", 64'(glog.size() >= g0 + 6), 64'd1);
    for (int k = 0; k < 6; k++)
      chk("rr_order", 64'(glog[g0+k][32]), 64'(k % 2));
    chk("rr_error", 64'(error), 64'd0);

    // Protocol violation: second I strobe while I is outstanding
    do_reset();
    lat_fix = 3;
    g0 = glog.size();
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle(1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 4'h0);
    cycle(1'b1, 32'h44, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("proto_error",  64'(error), 64'd1);
    chk("proto_ngrant", 64'(glog.size() - g0), 64'd1);
    chk("proto_grant",  64'(glog[g0]), 64'({1'b1, 32'h40}));

    // Timeout on a D write with an I request waiting behind it
    do_reset();
    lat_fix = 1000;
    g0 = glog.size();
    dready_cyc = -1;
    cycle(1'b0, 32'h0, 1'b1, 32'h300, 32'h12345678, 4'hF);
    lat_fix = 1;
    cycle(1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 20 && dready_cyc < 0; k++)
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("tmo_seen",  64'(dready_cyc >= 0), 64'd1);
    chk("tmo_when",  64'(dready_cyc - gcyc[g0]), 64'd7);
    chk("tmo_rdata", 64'(dready_rd), 64'd0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("tmo_error", 64'(error), 64'd2);
    chk("tmo_next",  64'(glog[g0+1]), 64'({1'b1, 32'h80}));
    chk("tmo_ngap",  64'(gcyc[g0+1] - dready_cyc), 64'd2);

    // Asynchronous reset while BUSY with I pending
    do_reset();
    lat_fix = 1000;
    cycle(1'b0, 32'h0,  1'b1, 32'h500, 32'hA5A5A5A5, 4'h0);
    cycle(1'b1, 32'h90, 1'b0, 32'h0,   32'h0,        4'h0);
    cycle(1'b0, 32'h0,  1'b1, 32'h504, 32'h0,        4'h0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("arst_mem_valid", 64'(mem_valid), 64'd0);
    chk("arst_mem_instr", 64'(mem_instr), 64'd0);
    chk("arst_mem_addr",  64'(mem_addr),  64'd0);
    chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("arst_error",     64'(error),     64'd0);
    chk("arst_ready",     64'({imem_ready, dmem_ready}), 64'd0);
    chk("arst_rdata",     64'({imem_rdata, dmem_rdata}), 64'd0);
    @(negedge clock);
    mem_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    g0 = glog.size();
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("arst_no_issue", 64'(glog.size() - g0), 64'd0);

    // Random traffic against the model
    do_reset();
    lat_fix = -1;
    for (int k = 0; k < 500; k++) begin
      cycle($urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing memory port between two requesters: instruction fetch (port I) and the execute-stage load/store/fence path behind the store buffer (port D).
- Buffers one request per port and issues at most one outstanding transaction.
- Grants round-robin when both ports are pending.
- Routes the memory acknowledge and read data back to the owning port.
- Aborts hung transactions after a programmable timeout.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT, 0, max cycles BUSY before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_valid  in  1  port I request strobe (one-cycle pulse).
- imem_addr  in  XLEN  port I address.
- imem_ready  out  1  port I completion.
- imem_rdata  out  XLEN  port I read data.
- dmem_valid  in  1  port D request strobe (one-cycle pulse).
- dmem_addr  in  XLEN  port D address.
- dmem_wdata  in  XLEN  port D write data.
- dmem_wstrb  in  XLEN/8  port D byte strobes; 0 means read.
- dmem_ready  out  1  port D completion.
- dmem_rdata  out  XLEN  port D read data.
- mem_valid  out  1  downstream request strobe, registered.
- mem_instr  out  1  1 = request owned by port I.
- mem_addr  out  XLEN  downstream address.
- mem_wdata  out  XLEN  downstream write data.
- mem_wstrb  out  XLEN/8  downstream byte strobes.
- mem_ready  in  1  downstream completion.
- mem_rdata  in  XLEN  downstream read data.
- error  out  2  sticky flags: [0] protocol violation, [1] timeout abort.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; pend_i=pend_d=0; last=I; cnt=0; error=0.
  - mem_valid=0, mem_instr=0, mem_addr/wdata/wstrb=0.
- Capture:
  - A valid pulse loads that port's pending slot (addr, wdata, wstrb; port I wstrb is forced to 0).
  - A valid on a port whose slot is full, or whose transaction is outstanding, is dropped and sets error[0].
- State IDLE:
  - If any slot is pending at the clock edge, select one and register mem_* from it. mem_valid=1 for exactly that one cycle. Clear the selected slot, set owner, go to BUSY, cnt=0.
  - Selection: if only one slot is pending, select it. If both are pending, select the port != last. After reset, D therefore wins the first tie.
  - Latency: a valid pulse in cycle N produces mem_valid in cycle N+1, provided the arbiter is IDLE with no competing request.
- State BUSY:
  - mem_valid=0; cnt increments each cycle.
  - On mem_ready=1:
    - Owner's ready=1 in the same cycle (combinational). Owner's rdata=mem_rdata.
    - Non-owner ready=0.
    - last=owner; go to IDLE.
  - The next pending request issues on the following edge, so the minimum gap between grants is 2 cycles.
  - Timeout: if TIMEOUT>0 and cnt==TIMEOUT-1 with mem_ready=0:
    - Owner's ready=1 with rdata=0 this cycle; error[1] set; go to IDLE.
    - A late mem_ready arriving while IDLE is ignored.
- Outputs when not acknowledging: imem_ready=dmem_ready=0; rdata outputs are 0.
- Simultaneous events:
  - A valid on the non-owner port in the same cycle as mem_ready is captured normally.
  - A valid on the owner port in the completion cycle is legal and captured, because its outstanding transaction ends that cycle.
- Flags: error bits clear only on reset.
- Reset mid-transaction: everything clears immediately and the outstanding response is discarded. The downstream memory is reset by the same signal.

Test Plan:
- Single D read:
  - Stimulus: dmem_valid at cycle 1 (addr 0x100, wstrb 0); mem_ready at cycle 4 with rdata 0xDEADBEEF.
  - Response: mem_valid=1 only at cycle 2 with mem_instr=0, addr 0x100. dmem_ready=1 at cycle 4 with dmem_rdata 0xDEADBEEF. imem_ready stays 0.
- Tie after reset:
  - Stimulus: imem_valid (0x0) and dmem_valid (0x200) in the same cycle; mem_ready after 1 cycle each time.
  - Response: first grant is D at 0x200, second grant is I at 0x0 with mem_instr=1. Grants are 2 cycles apart.
- Round-robin:
  - Stimulus: both ports re-request continuously for 6 grants.
  - Response: grant order D,I,D,I,D,I. No port receives two consecutive grants while the other is pending.
- Protocol violation:
  - Stimulus: second imem_valid while port I is outstanding.
  - Response: the request is dropped, error=2'b01, exactly one mem_valid with mem_instr=1.
- Timeout:
  - Stimulus: TIMEOUT=8; D write (wstrb 0xF); mem_ready never asserted.
  - Response: dmem_ready=1 with rdata 0 at the 8th BUSY cycle; error[1]=1; the next pending request issues on the following edge.
- Async reset mid-BUSY:
  - Stimulus: drop reset between clock edges while BUSY with I pending.
  - Response: all outputs are 0 immediately. After release with no valids, no mem_valid is issued.
